rf_read_stage_multi: RTL and testbench
======================================

// Module: rf_read_stage_multi
// PURPOSE
//  Generalised register-read stage between issue-select and the execute units.
//  Serves NUM_LANES issue lanes as one pipeline stage. Each lane reads two
//  physical-register sources, resolves same-cycle forwarding from NUM_BYPASS
//  result buses and optionally substitutes a sign-extended immediate.
//  Output sits behind a valid/ready-held pipeline register with flush.
// PARAMETERS
//  NUM_LANES   2   issue lanes handled in lock-step
//  NUM_BYPASS  3   forwarding buses snooped per operand
//  PRW         6   physical register index width (64 pregs)
//  ROBW        6   ROB_ID width
//  OPW         5   op code width
//  IMMW        20  immediate width (sign-extended to 32)
// PORTS
//  clk          in   1                    clock, rising edge
//  rst          in   1                    async reset, active-high
//  flush        in   1                    kill all in-flight/captured lanes
//  in_vld       in   NUM_LANES            per-lane select valid
//  in_ready     out  1                    stage accepts this cycle
//  in_op        in   NUM_LANES*OPW        op codes
//  in_imm       in   NUM_LANES*IMMW       immediates
//  in_src2_imm  in   NUM_LANES            1: operand 2 = sext(imm)
//  in_dest      in   NUM_LANES*PRW        destination preg
//  in_src1/2    in   NUM_LANES*PRW each   source pregs
//  in_rob_id    in   NUM_LANES*ROBW       ROB_ID
//  rf_raddr     out  NUM_LANES*2*PRW      regfile read addrs (lane l: src1 at 2l, src2 at 2l+1)
//  rf_rdata     in   NUM_LANES*2*32       regfile data, combinational same cycle
//  byp_vld      in   NUM_BYPASS           bypass bus valid
//  byp_pr       in   NUM_BYPASS*PRW       bypass preg
//  byp_data     in   NUM_BYPASS*32        bypass data
//  out_vld      out  NUM_LANES            registered lane valid
//  out_ready    in   1                    downstream accepts
//  out_op/dest/rob_id/pr_src1/pr_src2  out  per-lane, registered payload
//  out_data1/2  out  NUM_LANES*32 each    registered operand values
// BEHAVIOUR
//  - Reset (async, rst=1): out_vld=0; all payload/data outputs=0.
//  - in_ready = ~|out_vld | out_ready (combinational; all lanes advance together).
//  - Capture at posedge when in_ready: out_vld<=in_vld; payload loaded only for
//    lanes with in_vld=1, others hold. Latency 1 cycle select->out.
//  - in_ready=0: all out_* hold; in_* ignored (upstream must hold).
//  - flush=1: next cycle out_vld=0 regardless of in_ready/in_vld; beats capture.
//  - rf_raddr driven directly from in_src1/in_src2 (no register).
//  - Operand resolve, per source: preg==0 -> 32'h0, no bypass lookup. Else the
//    lowest-index bypass b with byp_vld[b] && byp_pr[b]==preg wins. Else rf_rdata.
//  - src2 with in_src2_imm=1: data2 = {{32-IMMW{imm[IMMW-1]}},imm}; out_pr_src2=0
//    so downstream bypass never matches it.
//  - Bypass is sampled only in capture cycle; held data is not re-snooped.
//  - Lanes independent: matches in lane 0 never affect lane 1 selection.
// STRUCTURE
//  - Shared pkg: PRW/ROBW/OPW/IMMW defaults, preg-zero constant, sext function.
//  - Sub-module operand_resolve (one per operand, 2*NUM_LANES instances):
//    preg, rf data, bypass buses -> 32-bit value; purely combinational.
//  - Top: in_ready logic, per-lane pipeline registers, flush/reset.
// TESTING
//  1 Reset: rst=1 mid-capture -> out_vld=0, out_data1/2=0 same cycle; rst=0, no in_vld -> stays 0.
//  2 Regfile read: lane0 src1=5, rf_rdata=32'h1234, no byp -> next cycle out_data1[0]=32'h1234, out_vld[0]=1.
//  3 Bypass priority: src1=7, byp0/byp2 both pr=7 data 0xA/0xC -> out_data1=0xA; only byp2 -> 0xC.
//  4 Zero/imm: src2=0 with byp pr=0 vld -> data2=0; src2_imm=1, imm=20'hFFFFE -> 32'hFFFFFFFE, pr_src2=0.
//  5 Stall: out_vld=1, out_ready=0 for 3 cycles, new in_vld -> in_ready=0, outputs unchanged; release -> new beat next cycle.
//  6 Flush: flush=1 with in_vld=2'b11 and stall -> out_vld=0 next cycle; in_ready=1 following cycle.

Source files
------------

// File: rtl/rf_read_stage_multi_pkg.sv
// Shared widths, the zero-register constant and the immediate sign-extension helper
// for the register-read stage.
package rf_read_stage_multi_pkg;

    localparam int DATA_W    = 32;
    localparam int PRW_DEF   = 6;
    localparam int ROBW_DEF  = 6;
    localparam int OPW_DEF   = 5;
    localparam int IMMW_DEF  = 20;
    localparam int PREG_ZERO = 0;

    // Sign-extend the low w bits of raw to a full data word.
    function automatic logic [DATA_W-1:0] sext_imm(input logic [DATA_W-1:0] raw, input int w);
        logic [DATA_W-1:0] mask;
        mask = (w >= DATA_W) ? '1 : ((DATA_W'(1) << w) - DATA_W'(1));
        return raw[w-1] ? (raw | ~mask) : (raw & mask);
    endfunction

endpackage

// File: rtl/rf_read_stage_multi_operand_resolve.sv
// Resolves one source operand: hard zero for preg 0, else lowest-index matching
// bypass bus, else the register-file value. Purely combinational.
module rf_read_stage_multi_operand_resolve
    import rf_read_stage_multi_pkg::*;
#(
    parameter int NUM_BYPASS = 3,
    parameter int PRW        = PRW_DEF
) (
    input  logic [PRW-1:0]               preg,
    input  logic [DATA_W-1:0]            rf_data,
    input  logic [NUM_BYPASS-1:0]        byp_vld,
    input  logic [NUM_BYPASS*PRW-1:0]    byp_pr,
    input  logic [NUM_BYPASS*DATA_W-1:0] byp_data,
    output logic [DATA_W-1:0]            value
);

    logic hit;

    always_comb begin
        value = rf_data;
        hit   = 1'b0;
        for (int b = 0; b < NUM_BYPASS; b++) begin
            if (!hit && byp_vld[b] && (byp_pr[b*PRW +: PRW] == preg)) begin
                value = byp_data[b*DATA_W +: DATA_W];
                hit   = 1'b1;
            end
        end
        // preg 0 is architecturally zero, so a bus tagged 0 must never leak in.
        if (preg == PRW'(PREG_ZERO)) begin
            value = '0;
        end
    end

endmodule

// File: rtl/rf_read_stage_multi.sv
// Multi-lane register-read stage: regfile address drive, per-operand forwarding,
// immediate substitution and a lock-step valid/ready output register with flush.
module rf_read_stage_multi
    import rf_read_stage_multi_pkg::*;
#(
    parameter int NUM_LANES  = 2,
    parameter int NUM_BYPASS = 3,
    parameter int PRW        = PRW_DEF,
    parameter int ROBW       = ROBW_DEF,
    parameter int OPW        = OPW_DEF,
    parameter int IMMW       = IMMW_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush,
    input  logic [NUM_LANES-1:0]           in_vld,
    output logic                           in_ready,
    input  logic [NUM_LANES*OPW-1:0]       in_op,
    input  logic [NUM_LANES*IMMW-1:0]      in_imm,
    input  logic [NUM_LANES-1:0]           in_src2_imm,
    input  logic [NUM_LANES*PRW-1:0]       in_dest,
    input  logic [NUM_LANES*PRW-1:0]       in_src1,
    input  logic [NUM_LANES*PRW-1:0]       in_src2,
    input  logic [NUM_LANES*ROBW-1:0]      in_rob_id,
    output logic [NUM_LANES*2*PRW-1:0]     rf_raddr,
    input  logic [NUM_LANES*2*DATA_W-1:0]  rf_rdata,
    input  logic [NUM_BYPASS-1:0]          byp_vld,
    input  logic [NUM_BYPASS*PRW-1:0]      byp_pr,
    input  logic [NUM_BYPASS*DATA_W-1:0]   byp_data,
    output logic [NUM_LANES-1:0]           out_vld,
    input  logic                           out_ready,
    output logic [NUM_LANES*OPW-1:0]       out_op,
    output logic [NUM_LANES*PRW-1:0]       out_dest,
    output logic [NUM_LANES*ROBW-1:0]      out_rob_id,
    output logic [NUM_LANES*PRW-1:0]       out_pr_src1,
    output logic [NUM_LANES*PRW-1:0]       out_pr_src2,
    output logic [NUM_LANES*DATA_W-1:0]    out_data1,
    output logic [NUM_LANES*DATA_W-1:0]    out_data2
);

    logic [NUM_LANES*DATA_W-1:0] res1, res2;
    logic                        capture;

    logic [NUM_LANES-1:0]        vld_q,    vld_d;
    logic [NUM_LANES*OPW-1:0]    op_q,     op_d;
    logic [NUM_LANES*PRW-1:0]    dest_q,   dest_d;
    logic [NUM_LANES*ROBW-1:0]   rob_q,    rob_d;
    logic [NUM_LANES*PRW-1:0]    pr1_q,    pr1_d;
    logic [NUM_LANES*PRW-1:0]    pr2_q,    pr2_d;
    logic [NUM_LANES*DATA_W-1:0] data1_q,  data1_d;
    logic [NUM_LANES*DATA_W-1:0] data2_q,  data2_d;

    assign in_ready = ~|vld_q | out_ready;
    assign capture  = in_ready & ~flush;

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign rf_raddr[(2*l)*PRW   +: PRW] = in_src1[l*PRW +: PRW];
        assign rf_raddr[(2*l+1)*PRW +: PRW] = in_src2[l*PRW +: PRW];

        rf_read_stage_multi_operand_resolve #(
            .NUM_BYPASS (NUM_BYPASS),
            .PRW        (PRW)
        ) u_res1 (
            .preg     (in_src1[l*PRW +: PRW]),
            .rf_data  (rf_rdata[(2*l)*DATA_W +: DATA_W]),
            .byp_vld  (byp_vld),
            .byp_pr   (byp_pr),
            .byp_data (byp_data),
            .value    (res1[l*DATA_W +: DATA_W])
        );

        rf_read_stage_multi_operand_resolve #(
            .NUM_BYPASS (NUM_BYPASS),
            .PRW        (PRW)
        ) u_res2 (
            .preg     (in_src2[l*PRW +: PRW]),
            .rf_data  (rf_rdata[(2*l+1)*DATA_W +: DATA_W]),
            .byp_vld  (byp_vld),
            .byp_pr   (byp_pr),
            .byp_data (byp_data),
            .value    (res2[l*DATA_W +: DATA_W])
        );
    end

    always_comb begin
        vld_d   = flush ? '0 : (in_ready ? in_vld : vld_q);
        op_d    = op_q;
        dest_d  = dest_q;
        rob_d   = rob_q;
        pr1_d   = pr1_q;
        pr2_d   = pr2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        // Idle lanes keep their old payload; only valid lanes are reloaded.
        for (int l = 0; l < NUM_LANES; l++) begin
            if (capture && in_vld[l]) begin
                op_d[l*OPW +: OPW]       = in_op[l*OPW +: OPW];
                dest_d[l*PRW +: PRW]     = in_dest[l*PRW +: PRW];
                rob_d[l*ROBW +: ROBW]    = in_rob_id[l*ROBW +: ROBW];
                pr1_d[l*PRW +: PRW]      = in_src1[l*PRW +: PRW];
                data1_d[l*DATA_W +: DATA_W] = res1[l*DATA_W +: DATA_W];
                if (in_src2_imm[l]) begin
                    // Zero tag keeps downstream forwarding from matching an immediate.
                    pr2_d[l*PRW +: PRW]         = '0;
                    data2_d[l*DATA_W +: DATA_W] = sext_imm(DATA_W'(in_imm[l*IMMW +: IMMW]), IMMW);
                end else begin
                    pr2_d[l*PRW +: PRW]         = in_src2[l*PRW +: PRW];
                    data2_d[l*DATA_W +: DATA_W] = res2[l*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= '0;
            op_q    <= '0;
            dest_q  <= '0;
            rob_q   <= '0;
            pr1_q   <= '0;
            pr2_q   <= '0;
            data1_q <= '0;
            data2_q <= '0;
        end else begin
            vld_q   <= vld_d;
            op_q    <= op_d;
            dest_q  <= dest_d;
            rob_q   <= rob_d;
            pr1_q   <= pr1_d;
            pr2_q   <= pr2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign out_vld     = vld_q;
    assign out_op      = op_q;
    assign out_dest    = dest_q;
    assign out_rob_id  = rob_q;
    assign out_pr_src1 = pr1_q;
    assign out_pr_src2 = pr2_q;
    assign out_data1   = data1_q;
    assign out_data2   = data2_q;

endmodule

// File: tb/tb_rf_read_stage_multi.sv
// Bench for rf_read_stage_multi: operand-resolve vector table, hand-written
// reset/immediate/stall/flush sequences, then randomized traffic against a model.
module tb_rf_read_stage_multi;

    localparam int NL   = 2;
    localparam int NB   = 3;
    localparam int PRW  = 6;
    localparam int ROBW = 6;
    localparam int OPW  = 5;
    localparam int IMMW = 20;
    localparam int OPF  = NL*OPW;
    localparam int IMF  = NL*IMMW;
    localparam int PRF  = NL*PRW;
    localparam int ROF  = NL*ROBW;
    localparam int BPF  = NB*PRW;

    logic                clk, rst, flush, in_ready, out_ready;
    logic [NL-1:0]       in_vld, in_src2_imm, out_vld;
    logic [OPF-1:0]      in_op, out_op;
    logic [IMF-1:0]      in_imm;
    logic [PRF-1:0]      in_dest, in_src1, in_src2, out_dest, out_pr_src1, out_pr_src2;
    logic [ROF-1:0]      in_rob_id, out_rob_id;
    logic [2*PRF-1:0]    rf_raddr;
    logic [NL*64-1:0]    rf_rdata;
    logic [NB-1:0]       byp_vld;
    logic [BPF-1:0]      byp_pr;
    logic [NB*32-1:0]    byp_data;
    logic [NL*32-1:0]    out_data1, out_data2;

    logic [31:0] regfile [64];

    rf_read_stage_multi #(
        .NUM_LANES(NL), .NUM_BYPASS(NB), .PRW(PRW), .ROBW(ROBW), .OPW(OPW), .IMMW(IMMW)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_vld(in_vld), .in_ready(in_ready),
        .in_op(in_op), .in_imm(in_imm), .in_src2_imm(in_src2_imm), .in_dest(in_dest),
        .in_src1(in_src1), .in_src2(in_src2), .in_rob_id(in_rob_id),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .byp_vld(byp_vld), .byp_pr(byp_pr), .byp_data(byp_data),
        .out_vld(out_vld), .out_ready(out_ready), .out_op(out_op), .out_dest(out_dest),
        .out_rob_id(out_rob_id), .out_pr_src1(out_pr_src1), .out_pr_src2(out_pr_src2),
        .out_data1(out_data1), .out_data2(out_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read on whatever address the stage presents.
    always_comb begin
        rf_rdata = '0;
        for (int i = 0; i < 2*NL; i++) begin
            rf_rdata[i*32 +: 32] = regfile[rf_raddr[i*PRW +: PRW]];
        end
    end

    int total = 0;
    int bad   = 0;

    // Reference state: what each output lane should hold.
    logic [NL-1:0] m_vld;
    logic [OPW-1:0]  m_op   [NL];
    logic [PRW-1:0]  m_dest [NL];
    logic [ROBW-1:0] m_rob  [NL];
    logic [PRW-1:0]  m_pr1  [NL];
    logic [PRW-1:0]  m_pr2  [NL];
    logic [31:0]     m_d1   [NL];
    logic [31:0]     m_d2   [NL];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_operand(input logic [PRW-1:0] p);
        if (p == 0) return 32'h0;
        for (int b = 0; b < NB; b++) begin
            if (byp_vld[b] && byp_pr[b*PRW +: PRW] == p) return byp_data[b*32 +: 32];
        end
        return regfile[p];
    endfunction

    task automatic model_reset();
        m_vld = '0;
        for (int l = 0; l < NL; l++) begin
            m_op[l] = '0; m_dest[l] = '0; m_rob[l] = '0; m_pr1[l] = '0;
            m_pr2[l] = '0; m_d1[l] = '0; m_d2[l] = '0;
        end
    endtask

    task automatic model_edge();
        logic rdy;
        logic [IMMW-1:0] imm;
        rdy = (m_vld == 0) || out_ready;
        if (flush) begin
            m_vld = '0;
        end else if (rdy) begin
            m_vld = in_vld;
            for (int l = 0; l < NL; l++) begin
                if (in_vld[l]) begin
                    m_op[l]   = in_op[l*OPW +: OPW];
                    m_dest[l] = in_dest[l*PRW +: PRW];
                    m_rob[l]  = in_rob_id[l*ROBW +: ROBW];
                    m_pr1[l]  = in_src1[l*PRW +: PRW];
                    m_d1[l]   = ref_operand(in_src1[l*PRW +: PRW]);
                    imm = in_imm[l*IMMW +: IMMW];
                    if (in_src2_imm[l]) begin
                        m_pr2[l] = '0;
                        m_d2[l]  = {{(32-IMMW){imm[IMMW-1]}}, imm};
                    end else begin
                        m_pr2[l] = in_src2[l*PRW +: PRW];
                        m_d2[l]  = ref_operand(in_src2[l*PRW +: PRW]);
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_vld"}, 64'(out_vld), 64'(m_vld));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'((m_vld == 0) || out_ready));
        for (int l = 0; l < NL; l++) begin
            chk($sformatf("%s.op[%0d]", tag, l),   64'(out_op[l*OPW +: OPW]),      64'(m_op[l]));
            chk($sformatf("%s.dest[%0d]", tag, l), 64'(out_dest[l*PRW +: PRW]),    64'(m_dest[l]));
            chk($sformatf("%s.rob[%0d]", tag, l),  64'(out_rob_id[l*ROBW +: ROBW]), 64'(m_rob[l]));
            chk($sformatf("%s.pr1[%0d]", tag, l),  64'(out_pr_src1[l*PRW +: PRW]), 64'(m_pr1[l]));
            chk($sformatf("%s.pr2[%0d]", tag, l),  64'(out_pr_src2[l*PRW +: PRW]), 64'(m_pr2[l]));
            chk($sformatf("%s.d1[%0d]", tag, l),   64'(out_data1[l*32 +: 32]),      64'(m_d1[l]));
            chk($sformatf("%s.d2[%0d]", tag, l),   64'(out_data2[l*32 +: 32]),      64'(m_d2[l]));
        end
    endtask

    task automatic tick(input string tag);
        model_edge();
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic clear_inputs();
        flush = 0; in_vld = '0; in_op = '0; in_imm = '0; in_src2_imm = '0;
        in_dest = '0; in_src1 = '0; in_src2 = '0; in_rob_id = '0;
        byp_vld = '0; byp_pr = '0; byp_data = '0; out_ready = 1'b1;
    endtask

    typedef struct {
        logic [PRW-1:0]  src1;
        logic [31:0]     rfval;
        logic [NB-1:0]   bvld;
        logic [BPF-1:0]  bpr;
        logic [NB*32-1:0] bdata;
        logic [31:0]     exp;
    } vec_t;

    vec_t vecs [6];

    initial begin
        // Bus fields are listed bus2, bus1, bus0 (MSB first).
        vecs[0] = '{6'd5, 32'h1234, 3'b000, {6'd0, 6'd0, 6'd0}, {32'h0, 32'h0, 32'h0}, 32'h1234};
        vecs[1] = '{6'd7, 32'h7777, 3'b101, {6'd7, 6'd3, 6'd7}, {32'hC, 32'hB, 32'hA}, 32'hA};
        vecs[2] = '{6'd7, 32'h7777, 3'b100, {6'd7, 6'd7, 6'd7}, {32'hC, 32'hB, 32'hA}, 32'hC};
        vecs[3] = '{6'd0, 32'h9999, 3'b111, {6'd0, 6'd0, 6'd0}, {32'h3, 32'h2, 32'h55}, 32'h0};
        vecs[4] = '{6'd9, 32'h9090, 3'b110, {6'd9, 6'd9, 6'd4}, {32'hD, 32'hB, 32'h1}, 32'hB};
        vecs[5] = '{6'd9, 32'h9191, 3'b111, {6'd8, 6'd1, 6'd2}, {32'hD, 32'hB, 32'h1}, 32'h9191};

        for (int i = 0; i < 64; i++) regfile[i] = $urandom;
        clear_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Operand-resolve table on lane 0 source 1.
        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            in_vld = 2'b01;
            in_src1[PRW-1:0] = vecs[i].src1;
            in_src2[PRW-1:0] = 6'd1;
            in_op[OPW-1:0] = OPW'(i + 1);
            regfile[vecs[i].src1] = vecs[i].rfval;
            byp_vld = vecs[i].bvld; byp_pr = vecs[i].bpr; byp_data = vecs[i].bdata;
            tick($sformatf("tbl%0d", i));
            chk($sformatf("tbl%0d.data1", i), 64'(out_data1[31:0]), 64'(vecs[i].exp));
        end

        // Zero source with a bus tagged 0, and immediates on lane 1.
        clear_inputs();
        in_vld = 2'b11;
        in_src2 = {6'd12, 6'd0};
        byp_vld = 3'b001; byp_pr = {6'd0, 6'd0, 6'd0}; byp_data = {32'h0, 32'h0, 32'hDEAD};
        in_src2_imm = 2'b10;
        in_imm = {20'hFFFFE, 20'h0};
        tick("imm_neg");
        chk("zero_src2", 64'(out_data2[31:0]), 64'h0);
        chk("imm_neg.data2", 64'(out_data2[63:32]), 64'hFFFF_FFFE);
        chk("imm_neg.pr2", 64'(out_pr_src2[11:6]), 64'h0);
        in_imm = {20'h7FFFF, 20'h0};
        tick("imm_pos");
        chk("imm_pos.data2", 64'(out_data2[63:32]), 64'h0007_FFFF);

        // Asynchronous reset landing while a beat is held.
        clear_inputs();
        in_vld = 2'b01; in_src1 = {6'd0, 6'd5};
        tick("pre_rst");
        rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        chk("rst_async.vld", 64'(out_vld), 64'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        in_vld = '0;
        tick("rst_idle0");
        tick("rst_idle1");

        // Stall: held beat, new select presented, downstream busy for 3 cycles.
        clear_inputs();
        in_vld = 2'b01; in_src1 = {6'd0, 6'd5}; in_op = {5'd0, 5'd17};
        tick("stall_load");
        out_ready = 1'b0;
        in_vld = 2'b11; in_src1 = {6'd21, 6'd22}; in_op = {5'd3, 5'd4}; in_rob_id = {6'd33, 6'd34};
        for (int c = 0; c < 3; c++) begin
            tick($sformatf("stall%0d", c));
            chk($sformatf("stall%0d.ready", c), 64'(in_ready), 64'h0);
            chk($sformatf("stall%0d.op0", c), 64'(out_op[4:0]), 64'd17);
        end
        out_ready = 1'b1;
        tick("stall_rel");
        chk("stall_rel.vld", 64'(out_vld), 64'h3);

        // Flush while stalled with both lanes valid.
        out_ready = 1'b0;
        tick("flush_pre");
        flush = 1'b1;
        tick("flush");
        chk("flush.vld", 64'(out_vld), 64'h0);
        flush = 1'b0; in_vld = '0;
        #1;
        chk("flush.ready_after", 64'(in_ready), 64'h1);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            in_vld      = NL'($urandom);
            in_src2_imm = NL'($urandom);
            in_op       = OPF'($urandom);
            in_imm      = IMF'({$urandom, $urandom});
            in_dest     = PRF'($urandom);
            in_rob_id   = ROF'($urandom);
            in_src1     = {PRW'($urandom_range(0, 15)), PRW'($urandom_range(0, 15))};
            in_src2     = {PRW'($urandom_range(0, 15)), PRW'($urandom_range(0, 15))};
            byp_vld     = NB'($urandom);
            byp_pr      = {PRW'($urandom_range(0, 15)), PRW'($urandom_range(0, 15)),
                           PRW'($urandom_range(0, 15))};
            byp_data    = {$urandom, $urandom, $urandom};
            out_ready   = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 15) == 0);
            regfile[$urandom_range(0, 63)] = $urandom;
            tick($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
